// File: rtl/ysyx_25020037_axi_sram_slv.sv
// AXI4 subordinate backed by a word-addressed on-chip SRAM array.
// Serves one transaction at a time; single-beat, FIXED and INCR bursts, configurable read latency.
module ysyx_25020037_axi_sram_slv #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd4 << DEPTH_LOG2);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    state_t      state, state_nx;
    logic [31:0] addr, addr_nx, addr_inc, rd_addr, rd_data;
    logic [7:0]  len, len_nx, beat, beat_nx;
    logic [2:0]  size, size_nx;
    logic [1:0]  burst, burst_nx;
    logic [3:0]  id, id_nx, lat, lat_nx;
    logic        bad, bad_nx, err, err_nx, over, over_nx;
    logic        rvalid_nx, rlast_nx, bvalid_nx;
    logic [31:0] rdata_nx;
    logic [1:0]  rresp_nx, bresp_nx;
    logic [3:0]  rid_nx, bid_nx;
    logic        ar_bad, aw_bad, rd_bad, rd_ok, wr_en;

    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT);
    endfunction

    assign arready  = rst && (state == IDLE);
    assign awready  = rst && (state == IDLE) && !arvalid;
    assign wready   = (state == WR_DATA);
    assign ar_bad   = (arsize > 3'd2) || (arburst == 2'b10);
    assign aw_bad   = (awsize > 3'd2) || (awburst == 2'b10);
    assign addr_inc = (burst == 2'b01) ? addr + (32'd1 << size) : addr;

    // The word presented on rdata next cycle: new AR address, latched address, or the next beat.
    always_comb begin
        rd_addr = addr;
        rd_bad  = bad;
        if (state == IDLE) begin
            rd_addr = araddr;
            rd_bad  = ar_bad;
        end else if (state == RD_DATA) begin
            rd_addr = addr_inc;
        end
    end

    assign rd_ok   = in_range(rd_addr) && !rd_bad;
    assign rd_data = rd_ok ? mem[rd_addr[DEPTH_LOG2+1:2]] : 32'd0;
    assign wr_en   = (state == WR_DATA) && wvalid && !bad && !over && in_range(addr);

    always_comb begin
        state_nx  = state;
        addr_nx   = addr;
        len_nx    = len;
        beat_nx   = beat;
        size_nx   = size;
        burst_nx  = burst;
        id_nx     = id;
        lat_nx    = lat;
        bad_nx    = bad;
        err_nx    = err;
        over_nx   = over;
        rvalid_nx = rvalid;
        rdata_nx  = rdata;
        rresp_nx  = rresp;
        rlast_nx  = rlast;
        rid_nx    = rid;
        bvalid_nx = bvalid;
        bresp_nx  = bresp;
        bid_nx    = bid;
        case (state)
            IDLE: begin
                if (arvalid) begin
                    id_nx    = arid;
                    len_nx   = arlen;
                    size_nx  = arsize;
                    burst_nx = arburst;
                    addr_nx  = araddr;
                    beat_nx  = 8'd0;
                    bad_nx   = ar_bad;
                    if (RD_LAT == 0) begin
                        state_nx  = RD_DATA;
                        rvalid_nx = 1'b1;
                        rdata_nx  = rd_data;
                        rresp_nx  = rd_ok ? 2'b00 : 2'b10;
                        rlast_nx  = (arlen == 8'd0);
                        rid_nx    = arid;
                    end else begin
                        state_nx = RD_WAIT;
                        lat_nx   = 4'(RD_LAT - 1);
                    end
                end else if (awvalid) begin
                    state_nx = WR_DATA;
                    id_nx    = awid;
                    len_nx   = awlen;
                    size_nx  = awsize;
                    burst_nx = awburst;
                    addr_nx  = awaddr;
                    beat_nx  = 8'd0;
                    bad_nx   = aw_bad;
                    err_nx   = 1'b0;
                    over_nx  = 1'b0;
                end
            end
            RD_WAIT: begin
                if (lat == 4'd0) begin
                    state_nx  = RD_DATA;
                    rvalid_nx = 1'b1;
                    rdata_nx  = rd_data;
                    rresp_nx  = rd_ok ? 2'b00 : 2'b10;
                    rlast_nx  = (len == 8'd0);
                    rid_nx    = id;
                end else begin
                    lat_nx = lat - 4'd1;
                end
            end
            RD_DATA: begin
                if (rready) begin
                    if (rlast) begin
                        state_nx  = IDLE;
                        rvalid_nx = 1'b0;
                        rlast_nx  = 1'b0;
                    end else begin
                        beat_nx  = beat + 8'd1;
                        addr_nx  = addr_inc;
                        rdata_nx = rd_data;
                        rresp_nx = rd_ok ? 2'b00 : 2'b10;
                        rlast_nx = (beat + 8'd1 == len);
                    end
                end
            end
            WR_DATA: begin
                if (wvalid) begin
                    // Beats past awlen are absorbed unwritten until wlast arrives.
                    if (!over) begin
                        beat_nx = beat + 8'd1;
                        addr_nx = addr_inc;
                        err_nx  = err || !in_range(addr);
                    end
                    if (wlast) begin
                        state_nx  = WR_RESP;
                        bvalid_nx = 1'b1;
                        bid_nx    = id;
                        bresp_nx  = (err || bad || over || !in_range(addr) || beat != len)
                                    ? 2'b10 : 2'b00;
                    end else if (!over && beat == len) begin
                        over_nx = 1'b1;
                    end
                end
            end
            WR_RESP: begin
                if (bready) begin
                    state_nx  = IDLE;
                    bvalid_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            addr   <= 32'd0;
            len    <= 8'd0;
            beat   <= 8'd0;
            size   <= 3'd0;
            burst  <= 2'd0;
            id     <= 4'd0;
            lat    <= 4'd0;
            bad    <= 1'b0;
            err    <= 1'b0;
            over   <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= 32'd0;
            rresp  <= 2'd0;
            rlast  <= 1'b0;
            rid    <= 4'd0;
            bvalid <= 1'b0;
            bresp  <= 2'd0;
            bid    <= 4'd0;
        end else begin
            state  <= state_nx;
            addr   <= addr_nx;
            len    <= len_nx;
            beat   <= beat_nx;
            size   <= size_nx;
            burst  <= burst_nx;
            id     <= id_nx;
            lat    <= lat_nx;
            bad    <= bad_nx;
            err    <= err_nx;
            over   <= over_nx;
            rvalid <= rvalid_nx;
            rdata  <= rdata_nx;
            rresp  <= rresp_nx;
            rlast  <= rlast_nx;
            rid    <= rid_nx;
            bvalid <= bvalid_nx;
            bresp  <= bresp_nx;
            bid    <= bid_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[addr[DEPTH_LOG2+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_axi_sram_slv.sv
// Directed self-checking bench for ysyx_25020037_axi_sram_slv (RD_LAT=1).
module tb_ysyx_25020037_axi_sram_slv;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awid, arid, wstrb, bid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;

    int checks = 0;
    int failures = 0;

    logic [31:0] rdData [16];
    logic [1:0]  rdResp [16];
    logic        rdLast [16];
    logic [3:0]  rdId   [16];
    int          rdLat;
    logic        awSeen, unstable;
    logic [1:0]  wResp;
    logic [3:0]  wId;

    always #5 clk = ~clk;

    ysyx_25020037_axi_sram_slv dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full read transaction; called and returns at 2 time units after a rising edge.
    task automatic applyRead(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int stallBeat, input int stallCycles);
        int cnt;
        araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1; rready = 1'b1; awSeen = 1'b0; unstable = 1'b0;
        #1;
        cnt = 0;
        while (arready !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
        if (cnt >= 50) checkOutput("ar_timeout", 32'd0, 32'd1);
        @(posedge clk); #1; arvalid = 1'b0; #1;
        rdLat = 0;
        while (rvalid !== 1'b1 && rdLat < 50) begin
            awSeen |= awready; @(posedge clk); #2; rdLat++;
        end
        for (int b = 0; b <= int'(len); b++) begin
            cnt = 0;
            while (rvalid !== 1'b1 && cnt < 50) begin awSeen |= awready; @(posedge clk); #2; cnt++; end
            if (cnt >= 50) checkOutput("r_timeout", 32'd0, 32'd1);
            rdData[b] = rdata; rdResp[b] = rresp; rdLast[b] = rlast; rdId[b] = rid;
            if (b == stallBeat) begin
                rready = 1'b0;
                for (int s = 0; s < stallCycles; s++) begin
                    awSeen |= awready;
                    @(posedge clk); #2;
                    if (rvalid !== 1'b1 || rdata !== rdData[b] || rlast !== rdLast[b]) unstable = 1'b1;
                end
                rready = 1'b1;
            end
            awSeen |= awready;
            @(posedge clk); #2;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                                 input logic [31:0] d [4], input int nbeats);
        int cnt;
        awaddr = a; awid = id; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        #1;
        cnt = 0;
        while (awready !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
        if (cnt >= 50) checkOutput("aw_timeout", 32'd0, 32'd1);
        @(posedge clk); #1; awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wdata = d[b]; wstrb = strb; wlast = (b == nbeats - 1); wvalid = 1'b1; #1;
            cnt = 0;
            while (wready !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
            if (cnt >= 50) checkOutput("w_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        checkOutput("b_timing", 32'(bvalid), 32'd1);
        wResp = bresp; wId = bid;
        bready = 1'b1;
        @(posedge clk); #1; bready = 1'b0; #1;
    endtask

    initial begin
        logic seen;
        rst = 1'b0;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_awready", 32'(awready), 32'd0);
        checkOutput("rst_rvalid",  32'(rvalid),  32'd0);
        checkOutput("rst_bvalid",  32'(bvalid),  32'd0);
        checkOutput("rst_wready",  32'(wready),  32'd0);
        checkOutput("rst_rdata",   rdata,        32'd0);
        checkOutput("rst_ids",     {24'd0, rid, bid}, 32'd0);
        rst = 1'b1; #1;
        checkOutput("idle_arready", 32'(arready), 32'd1);
        checkOutput("idle_awready", 32'(awready), 32'd1);

        // Single word write then read with latency check.
        applyStimulus(32'h8000_0010, 4'h1, 8'd0, 3'd2, 2'b01, 4'hF, '{32'hDEADBEEF, 0, 0, 0}, 1);
        checkOutput("w1_bresp", 32'(wResp), 32'd0);
        checkOutput("w1_bid",   32'(wId),   32'h1);
        applyRead(32'h8000_0010, 4'h2, 8'd0, 3'd2, 2'b01, -1, 0);
        checkOutput("r1_latency", rdLat, 32'd1);
        checkOutput("r1_data",  rdData[0], 32'hDEADBEEF);
        checkOutput("r1_last",  32'(rdLast[0]), 32'd1);
        checkOutput("r1_resp",  32'(rdResp[0]), 32'd0);
        checkOutput("r1_id",    32'(rdId[0]),   32'h2);

        // Byte lane store into the top byte.
        applyStimulus(32'h8000_0010, 4'h1, 8'd0, 3'd2, 2'b01, 4'hF, '{32'h11223344, 0, 0, 0}, 1);
        applyStimulus(32'h8000_0013, 4'h1, 8'd0, 3'd0, 2'b01, 4'h8, '{32'hAB000000, 0, 0, 0}, 1);
        applyRead(32'h8000_0013, 4'h2, 8'd0, 3'd2, 2'b01, -1, 0);
        checkOutput("byte_merge", rdData[0], 32'hAB223344);

        // INCR burst write then read with a three-cycle stall on the second beat.
        applyStimulus(32'h8000_0000, 4'h4, 8'd3, 3'd2, 2'b01, 4'hF, '{32'd1, 32'd2, 32'd3, 32'd4}, 4);
        checkOutput("incr_w_bresp", 32'(wResp), 32'd0);
        applyRead(32'h8000_0000, 4'h6, 8'd3, 3'd2, 2'b01, 1, 3);
        checkOutput("incr_data", {rdData[0][7:0], rdData[1][7:0], rdData[2][7:0], rdData[3][7:0]}, 32'h01020304);
        checkOutput("incr_last", {28'd0, rdLast[0], rdLast[1], rdLast[2], rdLast[3]}, 32'h1);
        checkOutput("stall_stable", 32'(unstable), 32'd0);

        // FIXED burst overwrites one word; INCR fills three.
        applyStimulus(32'h8000_0020, 4'h1, 8'd2, 3'd2, 2'b00, 4'hF, '{32'd5, 32'd6, 32'd7, 0}, 3);
        applyRead(32'h8000_0020, 4'h1, 8'd0, 3'd2, 2'b01, -1, 0);
        checkOutput("fixed_word", rdData[0], 32'd7);
        applyStimulus(32'h8000_0020, 4'h1, 8'd2, 3'd2, 2'b01, 4'hF, '{32'd5, 32'd6, 32'd7, 0}, 3);
        applyRead(32'h8000_0020, 4'h1, 8'd2, 3'd2, 2'b01, -1, 0);
        checkOutput("incr3_data", {8'd0, rdData[0][7:0], rdData[1][7:0], rdData[2][7:0]}, 32'h00050607);

        // Out-of-range and protocol errors.
        applyStimulus(32'h8000_1000, 4'h1, 8'd0, 3'd2, 2'b01, 4'hF, '{32'h5555AAAA, 0, 0, 0}, 1);
        applyRead(32'h0000_1000, 4'h1, 8'd0, 3'd2, 2'b01, -1, 0);
        checkOutput("oor_rresp", 32'(rdResp[0]), 32'd2);
        checkOutput("oor_rdata", rdData[0], 32'd0);
        applyStimulus(32'h0000_1000, 4'h1, 8'd1, 3'd2, 2'b01, 4'hF, '{32'hFFFFFFFF, 0, 0, 0}, 1);
        checkOutput("early_bresp", 32'(wResp), 32'd2);
        applyRead(32'h8000_1000, 4'h1, 8'd0, 3'd2, 2'b01, -1, 0);
        checkOutput("array_unchanged", rdData[0], 32'h5555AAAA);
        applyStimulus(32'h8000_0040, 4'h1, 8'd0, 3'd2, 2'b01, 4'hF, '{32'hA, 32'hB, 0, 0}, 2);
        checkOutput("late_bresp", 32'(wResp), 32'd2);
        applyRead(32'h8000_0040, 4'h1, 8'd0, 3'd2, 2'b01, -1, 0);
        checkOutput("late_word", rdData[0], 32'hA);
        applyRead(32'h8000_0000, 4'h1, 8'd0, 3'd2, 2'b10, -1, 0);
        checkOutput("wrap_rresp", 32'(rdResp[0]), 32'd2);
        checkOutput("wrap_rdata", rdData[0], 32'd0);

        // Simultaneous AR and AW: the read is served first.
        awaddr = 32'h8000_0040; awid = 4'h5; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        araddr = 32'h8000_0010; arid = 4'h3; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        #1;
        checkOutput("simul_awready", 32'(awready), 32'd0);
        checkOutput("simul_arready", 32'(arready), 32'd1);
        applyRead(32'h8000_0010, 4'h3, 8'd0, 3'd2, 2'b01, -1, 0);
        checkOutput("simul_rid", 32'(rdId[0]), 32'h3);
        checkOutput("simul_rdata", rdData[0], 32'hAB223344);
        checkOutput("simul_aw_blocked", 32'(awSeen), 32'd0);
        checkOutput("simul_aw_after", 32'(awready), 32'd1);
        applyStimulus(32'h8000_0040, 4'h5, 8'd0, 3'd2, 2'b01, 4'hF, '{32'h77, 0, 0, 0}, 1);
        checkOutput("simul_bid", 32'(wId), 32'h5);
        checkOutput("simul_bresp", 32'(wResp), 32'd0);

        // Reset while waiting for read data aborts the read.
        araddr = 32'h8000_0000; arid = 4'h7; arlen = 0; arvalid = 1'b1; #1;
        @(posedge clk); #1; arvalid = 1'b0; rst = 1'b0; #1;
        checkOutput("abort_rvalid", 32'(rvalid), 32'd0);
        checkOutput("abort_awready", 32'(awready), 32'd0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1; #1;
        seen = 1'b0;
        repeat (5) begin seen |= rvalid; @(posedge clk); #2; end
        checkOutput("abort_no_r", 32'(seen), 32'd0);
        checkOutput("abort_idle", 32'(arready), 32'd1);
        applyRead(32'h8000_0000, 4'h1, 8'd0, 3'd2, 2'b01, -1, 0);
        checkOutput("mem_kept", rdData[0], 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
